handshake_shared_arbiter: RTL and testbench

HANDSHAKE_SHARED_ARBITER -- requirements
Module: handshake_shared_arbiter

---
 rtl/handshake_shared_arbiter_if.sv | 25 ++
 rtl/handshake_shared_arbiter.sv | 104 ++++++++++
 tb/tb_handshake_shared_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/handshake_shared_arbiter_if.sv
// Handshake bundle between N requesters and the shared arbiter: per-requester
// valid/ready/data on the input side and a single valid/ready token on the output side.
interface handshake_shared_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 2
);
  logic [N_REQ*DATA_WIDTH-1:0] ins;
  logic [N_REQ-1:0]            ins_valid;
  logic [N_REQ-1:0]            ins_ready;
  logic [DATA_WIDTH-1:0]       outs;
  logic [IDX_WIDTH-1:0]        outs_index;
  logic                        outs_valid;
  logic                        outs_ready;

  modport master (
    output ins, ins_valid, outs_ready,
    input  ins_ready, outs, outs_index, outs_valid
  );

  modport slave (
    input  ins, ins_valid, outs_ready,
    output ins_ready, outs, outs_index, outs_valid
  );
endinterface

// File: rtl/handshake_shared_arbiter.sv
// N-to-1 arbiter feeding a one-entry registered output slot.
// HANDSHAKE_ARB_ROUND_ROBIN_EN selects rotating priority; otherwise lowest index wins.
//
// state | meaning
// EMPTY | output slot holds no token, any granted requester may load
// FULL  | output slot holds a token, reload only while downstream drains
module handshake_shared_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  handshake_shared_arbiter_if.slave     bus
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                state, state_nxt;
  logic                  can_load;
  logic                  found;
  logic                  accept;
  logic [IDX_WIDTH-1:0]  gnt;
  logic [IDX_WIDTH:0]    sum;
  logic [IDX_WIDTH-1:0]  cand;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic [DATA_WIDTH-1:0] outs_q;
  logic [IDX_WIDTH-1:0]  index_q;
  logic [IDX_WIDTH-1:0]  ptr;

`ifdef HANDSHAKE_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (gnt == IDX_WIDTH'(N_REQ - 1)) ? '0 : gnt + 1'b1;
    end
  end
`else
  assign ptr = '0;
`endif

  // Scan upward from ptr with wrap modulo N_REQ; ptr=0 gives fixed priority.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr} + (IDX_WIDTH+1)'(k);
      if (sum >= (IDX_WIDTH+1)'(N_REQ)) begin
        sum = sum - (IDX_WIDTH+1)'(N_REQ);
      end
      cand = sum[IDX_WIDTH-1:0];
      if (!found && bus.ins_valid[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt == IDX_WIDTH'(i)) begin
        gnt_data = bus.ins[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign can_load = (state == EMPTY) || bus.outs_ready;
  // rst gates ready so no requester sees a handshake while the slot is held in reset.
  assign accept   = found && can_load && rst;

  always_comb begin
    state_nxt     = state;
    bus.ins_ready = '0;
    if (accept) begin
      bus.ins_ready = N_REQ'(1) << gnt;
      state_nxt     = FULL;
    end else if (state == FULL && bus.outs_ready) begin
      state_nxt     = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= EMPTY;
      outs_q  <= '0;
      index_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        outs_q  <= gnt_data;
        index_q <= gnt;
      end
    end
  end

  assign bus.outs       = outs_q;
  assign bus.outs_index = index_q;
  assign bus.outs_valid = (state == FULL);

endmodule

// File: tb/tb_handshake_shared_arbiter.sv
// Randomized and directed bench for handshake_shared_arbiter (N_REQ=4, DATA_WIDTH=8)
// against an abstract slot/pointer reference model.
module tb_handshake_shared_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;

  handshake_shared_arbiter_if #(.N_REQ(4), .DATA_WIDTH(8), .IDX_WIDTH(2)) bus ();

  handshake_shared_arbiter #(.N_REQ(4), .DATA_WIDTH(8), .IDX_WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  bit       m_full = 1'b0;
  bit [7:0] m_data = 8'h00;
  int       m_idx  = 0;
  int       m_ptr  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit [7:0] slice_of(input logic [31:0] d, input int g);
    return 8'(d >> (8 * g));
  endfunction

  task automatic model_reset();
    m_full = 1'b0;
    m_data = 8'h00;
    m_idx  = 0;
    m_ptr  = 0;
  endtask

  // One cycle: drive at negedge, compare against the model, advance the model at posedge.
  task automatic step(input logic [3:0] v, input logic [31:0] d, input logic rdy);
    int       g;
    bit       can;
    bit [3:0] er;
    @(negedge clk);
    bus.ins_valid  = v;
    bus.ins        = d;
    bus.outs_ready = rdy;
    #1;
    g = -1;
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (m_ptr + k) % 4;
      if (g < 0 && ((v >> j) & 4'd1) != 4'd0) g = j;
    end
    can = !m_full || rdy;
    er  = (g >= 0 && can) ? 4'(1 << g) : 4'b0000;
    chk("ins_ready", {28'd0, bus.ins_ready}, {28'd0, er});
    chk("outs_valid", {31'd0, bus.outs_valid}, {31'd0, m_full});
    if (m_full) begin
      chk("outs", {24'd0, bus.outs}, {24'd0, m_data});
      chk("outs_index", {30'd0, bus.outs_index}, 32'(m_idx));
    end
    @(posedge clk);
    if (g >= 0 && can) begin
      m_full = 1'b1;
      m_data = slice_of(d, g);
      m_idx  = g;
`ifdef HANDSHAKE_ARB_ROUND_ROBIN_EN
      m_ptr  = (g + 1) % 4;
`endif
    end else if (m_full && rdy) begin
      m_full = 1'b0;
    end
  endtask

  task automatic do_reset();
    bus.ins_valid  = '0;
    bus.ins        = '0;
    bus.outs_ready = 1'b0;
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bus.ins_valid  = '0;
    bus.ins        = '0;
    bus.outs_ready = 1'b0;
    #2;
    chk("rst_outs_valid", {31'd0, bus.outs_valid}, 32'd0);
    chk("rst_outs", {24'd0, bus.outs}, 32'd0);
    chk("rst_ins_ready", {28'd0, bus.ins_ready}, 32'd0);
    do_reset();

    // single request after reset
    step(4'b0100, 32'h00A5_0000, 1'b1);
    #1;
    chk("single_outs", {24'd0, bus.outs}, 32'hA5);
    chk("single_index", {30'd0, bus.outs_index}, 32'd2);
    chk("single_valid", {31'd0, bus.outs_valid}, 32'd1);

    // all requesters valid, back-to-back draining
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, 32'h4433_2211, 1'b1);
      #1;
`ifdef HANDSHAKE_ARB_ROUND_ROBIN_EN
      chk("rr_index", {30'd0, bus.outs_index}, 32'(i % 4));
`else
      chk("fp_index", {30'd0, bus.outs_index}, 32'd0);
      chk("fp_ready_hi", {28'd0, bus.ins_ready & 4'b1110}, 32'd0);
`endif
      chk("stream_valid", {31'd0, bus.outs_valid}, 32'd1);
    end

    // backpressure hold, then drain and accept in the same cycle
    do_reset();
    step(4'b0001, 32'h0000_003C, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(4'b0010, 32'h0000_7700, 1'b0);
      #1;
      chk("hold_outs", {24'd0, bus.outs}, 32'h3C);
      chk("hold_ready", {28'd0, bus.ins_ready}, 32'd0);
    end
    step(4'b0010, 32'h0000_7700, 1'b1);
    #1;
    chk("drain_outs", {24'd0, bus.outs}, 32'h77);
    chk("drain_index", {30'd0, bus.outs_index}, 32'd1);

    // asynchronous reset while the slot is full
    step(4'b0001, 32'h0000_0055, 1'b1);
    #2;
    bus.ins_valid = 4'b1111;
    rst = 1'b0;
    model_reset();
    #1;
    chk("arst_valid", {31'd0, bus.outs_valid}, 32'd0);
    chk("arst_outs", {24'd0, bus.outs}, 32'd0);
    chk("arst_index", {30'd0, bus.outs_index}, 32'd0);
    chk("arst_ready", {28'd0, bus.ins_ready}, 32'd0);
    bus.ins_valid = 4'b0000;
    @(negedge clk);
    rst = 1'b1;
    step(4'b1000, 32'h9900_0000, 1'b1);
    #1;
    chk("post_rst_index", {30'd0, bus.outs_index}, 32'd3);
    chk("post_rst_outs", {24'd0, bus.outs}, 32'h99);

    // idle requesters leave slot empty and pointer untouched
    step(4'b0000, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(4'b0000, $urandom, 1'b1);
      #1;
      chk("idle_valid", {31'd0, bus.outs_valid}, 32'd0);
    end
    step(4'b1111, 32'hDDCC_BBAA, 1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [3:0] v;
      v = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      step(v, $urandom, 1'($urandom_range(0, 2) != 0));
    end
    step(4'b0000, 32'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
